// File: rtl/risc_mem_pkg.sv
// Shared types for the unified instruction/data memory port.
// Owner tags travel alongside reads so returned words reach the right requester.
package risc_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    typedef enum logic {
        NORMAL   = 1'b0,
        FORCE_IF = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_tag_pipe.sv
// Owner-tag delay line that tracks reads in flight through the memory.
// Latency DEPTH cycles; no backpressure, shifts every cycle.
// busy flags any stage still carrying a real read.
module mem_tag_pipe
    import risc_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] tag_in,
    output logic [1:0] tag_out,
    output logic       busy
);

    owner_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= OWN_NONE;
        end else begin
            stage_q[0] <= owner_t'(tag_in);
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tag_out = stage_q[DEPTH-1];

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) busy = busy | (stage_q[i] != OWN_NONE);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one single-port synchronous memory.
// Grant is combinational; read data returns RD_LAT+1 cycles after grant.
// Losers simply keep requesting; data wins unless fetch has been starved STREAK_MAX times.
module mem_port_arbiter
    import risc_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = 1,
    parameter int STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

    arb_state_t state_q, state_nxt;
    logic [3:0] streak_q, streak_nxt;
    owner_t     push_tag;
    logic [1:0] ret_tag;

    // Grants are masked while reset is held so nothing reaches the memory.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (reset) begin
            if (state_q == FORCE_IF) begin
                if_gnt = if_req;
                d_gnt  = d_req & ~if_req;
            end else begin
                d_gnt  = d_req;
                if_gnt = if_req & ~d_req;
            end
        end
    end

    always_comb begin
        mem_en   = if_gnt | d_gnt;
        mem_we   = d_gnt & d_we;
        mem_addr = '0;
        mem_din  = '0;
        push_tag = OWN_NONE;
        if (d_gnt) begin
            mem_addr = d_addr;
            mem_din  = d_wdata;
            if (!d_we) push_tag = OWN_D;
        end else if (if_gnt) begin
            mem_addr = if_addr;
            push_tag = OWN_IF;
        end
    end

    always_comb begin
        streak_nxt = streak_q;
        state_nxt  = state_q;
        if (!if_req || if_gnt) begin
            streak_nxt = '0;
        end else if (d_gnt) begin
            streak_nxt = streak_q + 4'd1;
        end
        case (state_q)
            NORMAL:   if (streak_nxt >= STREAK_LIM) state_nxt = FORCE_IF;
            FORCE_IF: if (if_gnt || !if_req) state_nxt = NORMAL;
            default:  state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= NORMAL;
            streak_q <= '0;
        end else begin
            state_q  <= state_nxt;
            streak_q <= streak_nxt;
        end
    end

    mem_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (push_tag),
        .tag_out (ret_tag),
        .busy    (busy)
    );

    // The tag leaving the pipe lines up with mem_dout for the same read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= (ret_tag == OWN_IF);
            d_rvalid  <= (ret_tag == OWN_D);
            if (ret_tag == OWN_IF) if_rdata <= mem_dout;
            if (ret_tag == OWN_D)  d_rdata  <= mem_dout;
        end
    end

endmodule
